// File: rtl/image_data_pkg.sv
// rtl/image_data_pkg.sv - PIO register map and FSM state encoding for the ImageData IRQ reader
package image_data_pkg;

    localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
    localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        RD_EC_A,
        RD_EC_D,
        WR_EC,
        RD_DAT_A,
        RD_DAT_D,
        PUSH
    } state_t;

endpackage

// File: rtl/image_data_irq_reader.sv
// rtl/image_data_irq_reader.sv - Avalon-MM initiator servicing the ImageData PIO IRQ; optional IMAGE_DATA_EVENT_CNT_EN
module image_data_irq_reader
    import image_data_pkg::*;
#(
    parameter logic [31:0] IRQ_MASK = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [1:0]  av_address,
    output logic        av_chipselect,
    output logic        av_write_n,
    output logic [31:0] av_writedata,
    input  logic [31:0] av_readdata,
    input  logic        pio_irq,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [31:0] out_events,
    output logic        busy,
    output logic [15:0] event_count
);

    state_t      state;
    state_t      next_state;
    logic        init_issued;
    logic [31:0] ec_q;
    logic [31:0] ec_masked;

    assign ec_masked = av_readdata & IRQ_MASK;

    always_comb begin
        next_state = state;
        case (state)
            INIT:     next_state = init_issued ? IDLE : INIT;
            IDLE:     if (pio_irq) next_state = RD_EC_A;
            RD_EC_A:  next_state = RD_EC_D;
            RD_EC_D:  next_state = (ec_masked == 32'd0) ? IDLE : WR_EC;
            WR_EC:    next_state = RD_DAT_A;
            RD_DAT_A: next_state = RD_DAT_D;
            RD_DAT_D: next_state = PUSH;
            PUSH:     if (out_ready) next_state = IDLE;
            default:  next_state = INIT;
        endcase
    end

    // Bus outputs are registered from next_state. INIT spends its first cycle
    // after reset arming the mask write, which then appears on the bus while INIT is held.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= INIT;
            init_issued   <= 1'b0;
            ec_q          <= 32'd0;
            av_address    <= 2'd0;
            av_chipselect <= 1'b0;
            av_write_n    <= 1'b1;
            av_writedata  <= 32'd0;
            out_valid     <= 1'b0;
            out_data      <= 32'd0;
            out_events    <= 32'd0;
            busy          <= 1'b1;
        end else begin
            state         <= next_state;
            busy          <= (next_state != IDLE);
            out_valid     <= (next_state == PUSH);
            av_chipselect <= 1'b0;
            av_write_n    <= 1'b1;

            if (state == INIT) init_issued <= 1'b1;
            if (state == RD_EC_D) ec_q <= ec_masked;
            if (state == RD_DAT_D) begin
                out_data   <= av_readdata;
                out_events <= ec_q;
            end

            case (next_state)
                INIT: begin
                    if (!init_issued) begin
                        av_address    <= PIO_ADDR_MASK;
                        av_chipselect <= 1'b1;
                        av_write_n    <= 1'b0;
                        av_writedata  <= IRQ_MASK;
                    end
                end
                RD_EC_A: begin
                    av_address    <= PIO_ADDR_EDGE;
                    av_chipselect <= 1'b1;
                end
                // Clearing only the serviced bits keeps later edges pending in the PIO.
                WR_EC: begin
                    av_address    <= PIO_ADDR_EDGE;
                    av_chipselect <= 1'b1;
                    av_write_n    <= 1'b0;
                    av_writedata  <= ec_masked;
                end
                RD_DAT_A: begin
                    av_address    <= PIO_ADDR_DATA;
                    av_chipselect <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef IMAGE_DATA_EVENT_CNT_EN
    logic [15:0] event_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            event_cnt_q <= 16'd0;
        end else if (state == PUSH && out_valid && out_ready && event_cnt_q != 16'hFFFF) begin
            event_cnt_q <= event_cnt_q + 16'd1;
        end
    end

    assign event_count = event_cnt_q;
`else
    assign event_count = 16'd0;
`endif

endmodule
